// File: rtl/sll_32_mc_pkg.sv
// Shared definitions for the multi-cycle shift units: word width, stage
// count and the state encoding used by the shifter FSMs.
package sll_32_mc_pkg;

    localparam int WORD_W       = 32;
    localparam int SHIFT_STAGES = 5;
    localparam int STAGE_W      = 3;
    localparam int AMT_W        = 5;

    // IDLE waits for work, SHIFT walks the amount bits, DONE presents the
    // finished result for one cycle while already accepting the next request.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/sll_var_stage.sv
// One variable-distance left shift step. Stage 0 shifts by 16, stage 1 by 8,
// down to stage 4 shifting by 1, so walking the stages MSB first rebuilds
// any 0-31 shift from the bits of the amount.
module sll_var_stage
    import sll_32_mc_pkg::*;
(
    input  logic [WORD_W-1:0]  value_i,
    input  logic [STAGE_W-1:0] stage_i,
    input  logic               en_i,
    output logic [WORD_W-1:0]  value_o
);

    localparam logic [AMT_W-1:0] FIRST_SHIFT = 5'd16;

    logic [AMT_W-1:0] shamt;

    // The distance halves with each stage; vacated bits fill with zero and
    // anything pushed past the top bit simply falls off.
    always_comb begin
        shamt   = FIRST_SHIFT >> stage_i;
        value_o = value_i;
        if (en_i) begin
            value_o = value_i << shamt;
        end
    end

endmodule

// File: rtl/sll_32_mc.sv
// Multi-cycle 32-bit logical left shifter. One amount bit is resolved per
// clock, MSB first, giving a fixed five-edge latency from accept to result
// that the pipeline stall logic relies on.
module sll_32_mc
    import sll_32_mc_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [AMT_W-1:0]    shift_amt,
    input  logic [WORD_W-1:0]   in,
    output logic [WORD_W-1:0]   out,
    output logic                ready,
    output logic                done
);

    localparam logic [STAGE_W-1:0] LAST_STAGE = 3'(SHIFT_STAGES - 1);

    state_e              state_q;
    logic [STAGE_W-1:0]  stage_q;
    logic [WORD_W-1:0]   work_q;
    logic [AMT_W-1:0]    amt_q;
    logic [WORD_W-1:0]   out_q;
    logic                done_q;

    logic [STAGE_W-1:0]  bitIdx;
    logic                stageEn;
    logic [WORD_W-1:0]   work_d;

    // Stage k consumes amount bit 4-k, so the largest distance goes first.
    always_comb begin
        bitIdx  = 3'd4 - stage_q;
        stageEn = amt_q[bitIdx];
    end

    sll_var_stage u_stage (
        .value_i (work_q),
        .stage_i (stage_q),
        .en_i    (stageEn),
        .value_o (work_d)
    );

    // Control FSM plus datapath registers. The result register only moves on
    // the completing edge so partial shifts never show on the output, and
    // done defaults low so it is a single-cycle pulse. Requests arriving
    // during SHIFT are dropped, not queued.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            stage_q <= '0;
            work_q  <= '0;
            amt_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        work_q  <= in;
                        amt_q   <= shift_amt;
                        stage_q <= '0;
                        state_q <= SHIFT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    work_q <= work_d;
                    if (stage_q == LAST_STAGE) begin
                        out_q   <= work_d;
                        done_q  <= 1'b1;
                        stage_q <= '0;
                        state_q <= DONE;
                    end else begin
                        stage_q <= stage_q + 3'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Ready is purely a view of the state: only SHIFT blocks new requests.
    always_comb begin
        ready = (state_q != SHIFT);
        out   = out_q;
        done  = done_q;
    end

endmodule

// File: tb/tb_sll_32_mc.sv
// Directed bench for the multi-cycle left shifter: reset state, several
// shift patterns, back-to-back issue, ignored start during SHIFT and a
// mid-operation reset, all against hand-computed results.
module tb_sll_32_mc;

    logic        clock;
    logic        reset;
    logic        start;
    logic [4:0]  shiftAmt;
    logic [31:0] inData;
    logic [31:0] outData;
    logic        ready;
    logic        done;

    int compareCount;
    int mismatchCount;

    sll_32_mc dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .shift_amt (shiftAmt),
        .in        (inData),
        .out       (outData),
        .ready     (ready),
        .done      (done)
    );

    // Free-running 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Present a request for exactly one accepting edge, then scramble the
    // operand inputs so any late sampling would corrupt the result.
    task automatic applyStimulus(input logic [31:0] value, input logic [4:0] amt);
        start    = 1'b1;
        inData   = value;
        shiftAmt = amt;
        @(posedge clock);
        #1;
        start    = 1'b0;
        inData   = $urandom;
        shiftAmt = 5'($urandom_range(31, 0));
    endtask

    // Walk the remaining edges of an accepted operation: output must hold its
    // previous value with done low through E4, then update with done on E5.
    task automatic waitResult(input string tag, input logic [31:0] expected,
                              input logic [31:0] prevOut);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clock);
            #1;
            checkOutput({tag, " done low"}, {31'b0, done}, 32'd0);
            checkOutput({tag, " out hold"}, outData, prevOut);
        end
        checkOutput({tag, " busy"}, {31'b0, ready}, 32'd0);
        @(posedge clock);
        #1;
        checkOutput({tag, " done"}, {31'b0, done}, 32'd1);
        checkOutput({tag, " ready"}, {31'b0, ready}, 32'd1);
        checkOutput({tag, " result"}, outData, expected);
    endtask

    // Main directed sequence.
    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        reset    = 1'b1;
        start    = 1'b0;
        shiftAmt = 5'd0;
        inData   = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        checkOutput("reset out", outData, 32'h0000_0000);
        checkOutput("reset done", {31'b0, done}, 32'd0);
        checkOutput("reset ready", {31'b0, ready}, 32'd1);

        repeat (3) @(posedge clock);
        #1;
        checkOutput("idle out", outData, 32'h0000_0000);
        checkOutput("idle done", {31'b0, done}, 32'd0);
        checkOutput("idle ready", {31'b0, ready}, 32'd1);

        applyStimulus(32'h0000_0001, 5'd31);
        waitResult("amt31", 32'h8000_0000, 32'h0000_0000);
        @(posedge clock);
        #1;
        checkOutput("pulse end", {31'b0, done}, 32'd0);
        checkOutput("out stable", outData, 32'h8000_0000);

        applyStimulus(32'hDEAD_BEEF, 5'd0);
        waitResult("amt0", 32'hDEAD_BEEF, 32'h8000_0000);
        @(posedge clock);
        #1;

        applyStimulus(32'hF000_000F, 5'd4);
        waitResult("amt4", 32'h0000_00F0, 32'hDEAD_BEEF);
        @(posedge clock);
        #1;

        applyStimulus(32'hFFFF_FFFF, 5'd16);
        waitResult("amt16", 32'hFFFF_0000, 32'h0000_00F0);
        @(posedge clock);
        #1;

        applyStimulus(32'h0000_0003, 5'd1);
        waitResult("b2b A", 32'h0000_0006, 32'hFFFF_0000);
        applyStimulus(32'h0000_0001, 5'd8);
        checkOutput("b2b done fall", {31'b0, done}, 32'd0);
        checkOutput("b2b accepted", {31'b0, ready}, 32'd0);
        waitResult("b2b B", 32'h0000_0100, 32'h0000_0006);
        @(posedge clock);
        #1;

        applyStimulus(32'h0000_0011, 5'd5);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        start    = 1'b1;
        inData   = 32'h1234_5678;
        shiftAmt = 5'd3;
        @(posedge clock);
        #1;
        start = 1'b0;
        checkOutput("ign busy", {31'b0, ready}, 32'd0);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        checkOutput("ign done", {31'b0, done}, 32'd1);
        checkOutput("ign result", outData, 32'h0000_0220);
        @(posedge clock);
        #1;
        checkOutput("ign not queued", {31'b0, ready}, 32'd1);
        checkOutput("ign no 2nd done", {31'b0, done}, 32'd0);

        applyStimulus(32'h0000_FFFF, 5'd8);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        checkOutput("rst mid out", outData, 32'h0000_0000);
        checkOutput("rst mid ready", {31'b0, ready}, 32'd1);
        checkOutput("rst mid done", {31'b0, done}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1;
            checkOutput("rst no pulse", {31'b0, done}, 32'd0);
        end

        applyStimulus(32'h0000_FFFF, 5'd8);
        waitResult("after rst", 32'h00FF_FF00, 32'h0000_0000);
        @(posedge clock);
        #1;

        reset    = 1'b1;
        start    = 1'b1;
        inData   = 32'h0000_0001;
        shiftAmt = 5'd1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        start = 1'b0;
        checkOutput("rst over start ready", {31'b0, ready}, 32'd1);
        checkOutput("rst over start out", outData, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
